// File: rtl/cpu_sram_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_sram_bridge_pkg
// Brief    : Shared widths and FSM state encoding for the CPU-to-SRAM bridge.
// Revision : 1.0 - initial release
// ============================================================================
package cpu_sram_bridge_pkg;

    localparam int c_addr_w = 32;
    localparam int c_data_w = 32;
    localparam int c_be_w   = c_data_w / 8;

    // Bundled memory request: {req, wen, addr, wdata}
    localparam int c_bridge_mem_wd = 1 + c_be_w + c_addr_w + c_data_w;

    typedef enum logic [2:0] {
        BR_IDLE   = 3'd0,
        BR_D_REQ  = 3'd1,
        BR_D_WAIT = 3'd2,
        BR_I_REQ  = 3'd3,
        BR_I_WAIT = 3'd4
    } br_state_t;

endpackage
`default_nettype wire

// File: rtl/cpu_sram_bridge_if.sv
`default_nettype none
// ============================================================================
// Module   : cpu_sram_bridge_if
// Brief    : Core SRAM ports plus shared memory port seen by the bridge.
//            master = the bridge itself, slave = core + memory environment.
// Revision : 1.0 - initial release
// ============================================================================
interface cpu_sram_bridge_if
    import cpu_sram_bridge_pkg::*;
#(
    parameter int ADDR_W = c_addr_w,
    parameter int DATA_W = c_data_w
);
    localparam int c_bw = DATA_W / 8;

    logic              inst_sram_en;
    logic [c_bw-1:0]   inst_sram_wen;
    logic [ADDR_W-1:0] inst_sram_addr;
    logic [DATA_W-1:0] inst_sram_wdata;
    logic [DATA_W-1:0] inst_sram_rdata;

    logic              data_sram_en;
    logic [c_bw-1:0]   data_sram_wen;
    logic [ADDR_W-1:0] data_sram_addr;
    logic [DATA_W-1:0] data_sram_wdata;
    logic [DATA_W-1:0] data_sram_rdata;

    logic              stallreq;

    logic              mem_req;
    logic [c_bw-1:0]   mem_wen;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_addr_ok;
    logic              mem_data_ok;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        input  inst_sram_en, inst_sram_wen, inst_sram_addr, inst_sram_wdata,
        input  data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
        input  mem_addr_ok, mem_data_ok, mem_rdata,
        output inst_sram_rdata, data_sram_rdata, stallreq,
        output mem_req, mem_wen, mem_addr, mem_wdata
    );

    modport slave (
        output inst_sram_en, inst_sram_wen, inst_sram_addr, inst_sram_wdata,
        output data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
        output mem_addr_ok, mem_data_ok, mem_rdata,
        input  inst_sram_rdata, data_sram_rdata, stallreq,
        input  mem_req, mem_wen, mem_addr, mem_wdata
    );

endinterface
`default_nettype wire

// File: rtl/cpu_sram_bridge_sram_port_hold.sv
`default_nettype none
// ============================================================================
// Module   : sram_port_hold
// Brief    : Per-port completion flag and read-data capture register.
// Revision : 1.0 - initial release
// ============================================================================
module sram_port_hold
    import cpu_sram_bridge_pkg::*;
#(
    parameter int DATA_W = c_data_w
) (
    input  wire                clk,
    input  wire                rst,
    input  wire                i_set_done,
    input  wire                i_clr_done,
    input  wire                i_capture,
    input  wire [DATA_W-1:0]   i_cap_data,
    output logic               o_done,
    output logic [DATA_W-1:0]  o_rdata
);

    logic              r_done;
    logic [DATA_W-1:0] r_rdata;

    // Done flag: set when this port's transaction finishes, cleared in the completion cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_done <= 1'b0;
        end else if (i_set_done) begin
            r_done <= 1'b1;
        end else if (i_clr_done) begin
            r_done <= 1'b0;
        end
    end

    // Read data register holds its value until the next read completes on this port
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata <= '0;
        end else if (i_capture) begin
            r_rdata <= i_cap_data;
        end
    end

    assign o_done  = r_done;
    assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/cpu_sram_bridge.sv
`default_nettype none
// ============================================================================
// Module   : cpu_sram_bridge
// Brief    : Serialises the core's inst/data SRAM ports onto one variable-
//            latency memory port, data first, stalling the core meanwhile.
//            Optional macro BRIDGE_PERF_CNT_EN adds stall/transfer counters.
// Revision : 1.0 - initial release
// ============================================================================
module cpu_sram_bridge
    import cpu_sram_bridge_pkg::*;
#(
    parameter int ADDR_W = c_addr_w,
    parameter int DATA_W = c_data_w
) (
    input  wire                 clk,
    input  wire                 rst,
    cpu_sram_bridge_if.master   bus
`ifdef BRIDGE_PERF_CNT_EN
    ,
    output logic [31:0]         stall_cycles,
    output logic [31:0]         mem_xfers
`endif
);

    localparam int c_bw     = DATA_W / 8;
    localparam int c_mem_wd = 1 + c_bw + ADDR_W + DATA_W;

    br_state_t          r_state;
    br_state_t          w_state_nxt;
    logic [c_mem_wd-1:0] w_mem_bus;
    logic               w_d_done;
    logic               w_i_done;
    logic               w_d_pend;
    logic               w_i_pend;
    logic               w_stall;
    logic               w_d_set;
    logic               w_i_set;
    logic               w_d_cap;
    logic               w_unused_inst_wr;

    // The fetch port never writes; its write-side inputs are intentionally dropped
    assign w_unused_inst_wr = ^{bus.inst_sram_wen, bus.inst_sram_wdata};

    assign w_d_pend     = bus.data_sram_en & ~w_d_done;
    assign w_i_pend     = bus.inst_sram_en & ~w_i_done;
    assign w_stall      = w_d_pend | w_i_pend;
    assign bus.stallreq = w_stall;

    assign {bus.mem_req, bus.mem_wen, bus.mem_addr, bus.mem_wdata} = w_mem_bus;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= BR_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and memory request mux; request fields are only non-zero in REQ states
    always_comb begin
        w_state_nxt = r_state;
        w_mem_bus   = '0;
        w_d_set     = 1'b0;
        w_i_set     = 1'b0;
        case (r_state)
            BR_IDLE: begin
                if (w_d_pend) begin
                    w_state_nxt = BR_D_REQ;
                end else if (w_i_pend) begin
                    w_state_nxt = BR_I_REQ;
                end
            end
            BR_D_REQ: begin
                w_mem_bus = {1'b1, bus.data_sram_wen, bus.data_sram_addr, bus.data_sram_wdata};
                if (bus.mem_addr_ok) begin
                    if (bus.mem_data_ok) begin
                        w_d_set     = 1'b1;
                        w_state_nxt = BR_IDLE;
                    end else begin
                        w_state_nxt = BR_D_WAIT;
                    end
                end
            end
            BR_D_WAIT: begin
                if (bus.mem_data_ok) begin
                    w_d_set     = 1'b1;
                    w_state_nxt = BR_IDLE;
                end
            end
            BR_I_REQ: begin
                w_mem_bus = {1'b1, {c_bw{1'b0}}, bus.inst_sram_addr, {DATA_W{1'b0}}};
                if (bus.mem_addr_ok) begin
                    if (bus.mem_data_ok) begin
                        w_i_set     = 1'b1;
                        w_state_nxt = BR_IDLE;
                    end else begin
                        w_state_nxt = BR_I_WAIT;
                    end
                end
            end
            BR_I_WAIT: begin
                if (bus.mem_data_ok) begin
                    w_i_set     = 1'b1;
                    w_state_nxt = BR_IDLE;
                end
            end
            default: begin
                w_state_nxt = BR_IDLE;
            end
        endcase
    end

    // Stores complete without touching the load data register
    assign w_d_cap = w_d_set & (bus.data_sram_wen == '0);

    sram_port_hold #(
        .DATA_W     (DATA_W)
    ) u_data_hold (
        .clk        (clk),
        .rst        (rst),
        .i_set_done (w_d_set),
        .i_clr_done (~w_stall),
        .i_capture  (w_d_cap),
        .i_cap_data (bus.mem_rdata),
        .o_done     (w_d_done),
        .o_rdata    (bus.data_sram_rdata)
    );

    sram_port_hold #(
        .DATA_W     (DATA_W)
    ) u_inst_hold (
        .clk        (clk),
        .rst        (rst),
        .i_set_done (w_i_set),
        .i_clr_done (~w_stall),
        .i_capture  (w_i_set),
        .i_cap_data (bus.mem_rdata),
        .o_done     (w_i_done),
        .o_rdata    (bus.inst_sram_rdata)
    );

`ifdef BRIDGE_PERF_CNT_EN
    logic [31:0] r_stall_cycles;
    logic [31:0] r_mem_xfers;

    // Free-running wrap-around counters of stalled cycles and finished transactions
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cycles <= 32'd0;
            r_mem_xfers    <= 32'd0;
        end else begin
            if (w_stall) begin
                r_stall_cycles <= r_stall_cycles + 32'd1;
            end
            if (w_d_set | w_i_set) begin
                r_mem_xfers <= r_mem_xfers + 32'd1;
            end
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign mem_xfers    = r_mem_xfers;
`endif

    // The core must keep a request asserted for as long as it is stalled on it
    a_data_en_held: assert property (@(posedge clk) disable iff (rst)
        (bus.stallreq && bus.data_sram_en) |=> bus.data_sram_en);
    a_inst_en_held: assert property (@(posedge clk) disable iff (rst)
        (bus.stallreq && bus.inst_sram_en) |=> bus.inst_sram_en);

endmodule
`default_nettype wire

// File: tb/tb_cpu_sram_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_sram_bridge
// Brief    : Scoreboard bench for cpu_sram_bridge with a latency-programmable
//            memory responder and a decoupled output monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_sram_bridge;

    logic clk = 1'b0;
    logic rst = 1'b1;

    cpu_sram_bridge_if #(.ADDR_W(32), .DATA_W(32)) bus ();

`ifdef BRIDGE_PERF_CNT_EN
    logic [31:0] stall_cycles;
    logic [31:0] mem_xfers;
`endif

    cpu_sram_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus)
`ifdef BRIDGE_PERF_CNT_EN
        ,
        .stall_cycles (stall_cycles),
        .mem_xfers    (mem_xfers)
`endif
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Memory responder latency knobs
    int ad = 0;
    int dd = 0;
    bit late_pulse = 1'b0;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  wen;
        logic [31:0] wdata;
        logic        chk_wdata;
    } req_t;

    typedef struct packed {
        logic        chk_i;
        logic [31:0] i_val;
        logic        chk_d;
        logic [31:0] d_val;
    } cpl_t;

    req_t exp_req_q[$];
    cpl_t exp_cpl_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%08h required=%08h", name, act, exp);
        end
    endtask

    task automatic flag(input string name);
        checks++;
        failures++;
        $display("FAIL %s", name);
    endtask

    function automatic logic [31:0] mem_lookup(input logic [31:0] a);
        case (a)
            32'hBFC0_0000: return 32'h3C01_0001;
            32'hBFC0_0004: return 32'h2402_0005;
            32'hBFC0_0008: return 32'h8C43_0004;
            32'h8000_0010: return 32'h1234_5678;
            32'h8000_0030: return 32'hCAFE_F00D;
            32'h8000_0040: return 32'h55AA_55AA;
            default:       return 32'hDEAD_DEAD;
        endcase
    endfunction

    // Memory model: addr_ok after 'ad' REQ cycles, data_ok 'dd' cycles after addr_ok
    initial begin : responder
        int phase;
        int cnt;
        bit just;
        logic [31:0] la;
        logic [3:0]  lw;
        phase = 0;
        cnt   = 0;
        la    = '0;
        lw    = '0;
        bus.mem_addr_ok = 1'b0;
        bus.mem_data_ok = 1'b0;
        bus.mem_rdata   = '0;
        forever begin
            @(negedge clk);
            #1;
            bus.mem_addr_ok = 1'b0;
            bus.mem_data_ok = 1'b0;
            just = 1'b0;
            if (rst) begin
                phase = 0;
            end else begin
                if (late_pulse) begin
                    bus.mem_data_ok = 1'b1;
                    bus.mem_rdata   = 32'hBAD0_BAD0;
                    late_pulse      = 1'b0;
                end
                if (phase == 0 && bus.mem_req) begin
                    phase = 1;
                    cnt   = ad;
                    la    = bus.mem_addr;
                    lw    = bus.mem_wen;
                end
                if (phase == 1) begin
                    if (cnt == 0) begin
                        bus.mem_addr_ok = 1'b1;
                        phase = 2;
                        cnt   = dd;
                        just  = 1'b1;
                    end else begin
                        cnt--;
                    end
                end
                if (phase == 2) begin
                    if (!just) cnt--;
                    if (cnt == 0) begin
                        bus.mem_data_ok = 1'b1;
                        bus.mem_rdata   = (lw != 4'd0) ? 32'hFFFF_FFFF : mem_lookup(la);
                        phase = 0;
                    end
                end
            end
        end
    end

    // Monitor: pops expected requests and completions as the DUT presents them
    initial begin : monitor
        bit active;
        logic [31:0] s_addr;
        logic [31:0] s_wdata;
        logic [3:0]  s_wen;
        req_t er;
        cpl_t ec;
        active  = 1'b0;
        s_addr  = '0;
        s_wdata = '0;
        s_wen   = '0;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                active = 1'b0;
            end else begin
                if (bus.mem_req) begin
                    if (!active) begin
                        if (exp_req_q.size() == 0) begin
                            flag("req_unexpected");
                        end else begin
                            er = exp_req_q.pop_front();
                            check("req_addr", bus.mem_addr, er.addr);
                            check("req_wen", {28'd0, bus.mem_wen}, {28'd0, er.wen});
                            if (er.chk_wdata) check("req_wdata", bus.mem_wdata, er.wdata);
                        end
                        active  = 1'b1;
                        s_addr  = bus.mem_addr;
                        s_wdata = bus.mem_wdata;
                        s_wen   = bus.mem_wen;
                    end else begin
                        check("hold_addr", bus.mem_addr, s_addr);
                        check("hold_wdata", bus.mem_wdata, s_wdata);
                        check("hold_wen", {28'd0, bus.mem_wen}, {28'd0, s_wen});
                    end
                    if (bus.mem_addr_ok) active = 1'b0;
                end
                if ((bus.inst_sram_en || bus.data_sram_en) && !bus.stallreq) begin
                    if (exp_cpl_q.size() == 0) begin
                        flag("cpl_unexpected");
                    end else begin
                        ec = exp_cpl_q.pop_front();
                        if (ec.chk_i) check("inst_rdata", bus.inst_sram_rdata, ec.i_val);
                        if (ec.chk_d) check("data_rdata", bus.data_sram_rdata, ec.d_val);
                    end
                end
            end
        end
    end

    // Present a core request, count stalled cycles, release after the completion cycle
    task automatic run_txn(input bit ie, input logic [3:0] iw, input logic [31:0] ia, input logic [31:0] iwd,
                           input bit de, input logic [3:0] dw, input logic [31:0] da, input logic [31:0] dwd,
                           output int stall_n);
        bit cleared;
        @(posedge clk);
        #1;
        bus.inst_sram_en    = ie;
        bus.inst_sram_wen   = iw;
        bus.inst_sram_addr  = ia;
        bus.inst_sram_wdata = iwd;
        bus.data_sram_en    = de;
        bus.data_sram_wen   = dw;
        bus.data_sram_addr  = da;
        bus.data_sram_wdata = dwd;
        stall_n = 0;
        cleared = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            #2;
            if (!bus.stallreq) begin
                cleared = 1'b1;
                break;
            end
            stall_n++;
        end
        if (!cleared) flag("stall_timeout");
        @(posedge clk);
        #1;
        bus.inst_sram_en = 1'b0;
        bus.data_sram_en = 1'b0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog_expired");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int n;
        bit cleared;
        bus.inst_sram_en    = 1'b0;
        bus.inst_sram_wen   = 4'd0;
        bus.inst_sram_addr  = '0;
        bus.inst_sram_wdata = '0;
        bus.data_sram_en    = 1'b0;
        bus.data_sram_wen   = 4'd0;
        bus.data_sram_addr  = '0;
        bus.data_sram_wdata = '0;

        // Reset state
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #2;
        check("rst_mem_req", {31'd0, bus.mem_req}, 32'd0);
        check("rst_mem_wen", {28'd0, bus.mem_wen}, 32'd0);
        check("rst_mem_addr", bus.mem_addr, 32'd0);
        check("rst_mem_wdata", bus.mem_wdata, 32'd0);
        check("rst_inst_rdata", bus.inst_sram_rdata, 32'd0);
        check("rst_data_rdata", bus.data_sram_rdata, 32'd0);
        check("rst_stallreq", {31'd0, bus.stallreq}, 32'd0);
`ifdef BRIDGE_PERF_CNT_EN
        check("rst_stall_cycles", stall_cycles, 32'd0);
        check("rst_mem_xfers", mem_xfers, 32'd0);
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;

        // 1: fetch only
        ad = 0; dd = 2;
        exp_req_q.push_back('{32'hBFC0_0000, 4'd0, 32'd0, 1'b0});
        exp_cpl_q.push_back('{1'b1, 32'h3C01_0001, 1'b0, 32'd0});
        run_txn(1'b1, 4'd0, 32'hBFC0_0000, 32'd0, 1'b0, 4'd0, 32'd0, 32'd0, n);
        check("t1_stall_cycles", n, 32'd4);

        // 2: fetch and load together, data goes first
        exp_req_q.push_back('{32'h8000_0010, 4'd0, 32'd0, 1'b1});
        exp_req_q.push_back('{32'hBFC0_0004, 4'd0, 32'd0, 1'b0});
        exp_cpl_q.push_back('{1'b1, 32'h2402_0005, 1'b1, 32'h1234_5678});
        run_txn(1'b1, 4'd0, 32'hBFC0_0004, 32'd0, 1'b1, 4'd0, 32'h8000_0010, 32'd0, n);
        check("t2_stall_cycles", n, 32'd8);

        // 3: partial store; load register untouched
        ad = 1; dd = 1;
        exp_req_q.push_back('{32'h8000_0020, 4'b0011, 32'hDEAD_BEEF, 1'b1});
        exp_cpl_q.push_back('{1'b0, 32'd0, 1'b1, 32'h1234_5678});
        run_txn(1'b0, 4'd0, 32'd0, 32'd0, 1'b1, 4'b0011, 32'h8000_0020, 32'hDEAD_BEEF, n);
        check("t3_stall_cycles", n, 32'd4);

        // 4: addr_ok withheld for 5 cycles
        ad = 5; dd = 1;
        exp_req_q.push_back('{32'h8000_0050, 4'b1111, 32'h0BAD_CAFE, 1'b1});
        exp_cpl_q.push_back('{1'b0, 32'd0, 1'b1, 32'h1234_5678});
        run_txn(1'b0, 4'd0, 32'd0, 32'd0, 1'b1, 4'b1111, 32'h8000_0050, 32'h0BAD_CAFE, n);
        check("t4_stall_cycles", n, 32'd8);

        // 5: addr_ok and data_ok together, no WAIT cycle
        ad = 0; dd = 0;
        exp_req_q.push_back('{32'h8000_0030, 4'd0, 32'd0, 1'b1});
        exp_cpl_q.push_back('{1'b0, 32'd0, 1'b1, 32'hCAFE_F00D});
        run_txn(1'b0, 4'd0, 32'd0, 32'd0, 1'b1, 4'd0, 32'h8000_0030, 32'd0, n);
        check("t5_stall_cycles", n, 32'd2);

        // 7: fetch-port write enables are ignored
        ad = 0; dd = 1;
        exp_req_q.push_back('{32'hBFC0_0008, 4'd0, 32'd0, 1'b0});
        exp_cpl_q.push_back('{1'b1, 32'h8C43_0004, 1'b1, 32'hCAFE_F00D});
        run_txn(1'b1, 4'b1111, 32'hBFC0_0008, 32'hFFFF_0000, 1'b0, 4'd0, 32'd0, 32'd0, n);
        check("t7_stall_cycles", n, 32'd3);

        // 6: reset during D_WAIT, then a stray data_ok in IDLE
        ad = 0; dd = 3;
        exp_req_q.push_back('{32'h8000_0040, 4'd0, 32'd0, 1'b1});
        exp_req_q.push_back('{32'h8000_0040, 4'd0, 32'd0, 1'b1});
        exp_cpl_q.push_back('{1'b0, 32'd0, 1'b1, 32'h55AA_55AA});
        @(posedge clk);
        #1;
        bus.data_sram_en    = 1'b1;
        bus.data_sram_wen   = 4'd0;
        bus.data_sram_addr  = 32'h8000_0040;
        bus.data_sram_wdata = 32'd0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        late_pulse = 1'b1;
        @(negedge clk);
        #2;
        check("t6_mem_req_after_rst", {31'd0, bus.mem_req}, 32'd0);
        check("t6_stallreq_follows_en", {31'd0, bus.stallreq}, 32'd1);
`ifdef BRIDGE_PERF_CNT_EN
        check("t6_stall_cycles_cleared", stall_cycles, 32'd0);
        check("t6_mem_xfers_cleared", mem_xfers, 32'd0);
`endif
        @(negedge clk);
        #2;
        check("t6_late_data_ignored", bus.data_sram_rdata, 32'd0);
        check("t6_reissue_req", {31'd0, bus.mem_req}, 32'd1);
        cleared = 1'b0;
        for (int k = 0; k < 60; k++) begin
            if (!bus.stallreq) begin
                cleared = 1'b1;
                break;
            end
            @(negedge clk);
            #2;
        end
        if (!cleared) flag("t6_stall_timeout");
`ifdef BRIDGE_PERF_CNT_EN
        check("t6_stall_cycles", stall_cycles, 32'd5);
        check("t6_mem_xfers", mem_xfers, 32'd1);
`endif
        @(posedge clk);
        #1;
        bus.data_sram_en = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        #3;
        check("req_queue_drained", exp_req_q.size(), 32'd0);
        check("cpl_queue_drained", exp_cpl_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
